// File: rtl/fetch_unit.sv
// Instruction fetch stage: ROM req/ack fetcher, small instruction FIFO,
// valid/ready presentation of IR/OPCODE/PC to execute, redirect flush.
// Optional build macro FETCH_STATS_EN adds saturating accept/redirect counters.
module fetch_unit #(
  parameter int unsigned        FIFO_DEPTH = 2,
  parameter int unsigned        ADDR_W     = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0
) (
  input  logic              iCLK,
  input  logic              iRST,
  output logic              oROM_REQ,
  output logic [ADDR_W-1:0] oROM_ADDR,
  input  logic              iROM_ACK,
  input  logic [31:0]       iROM_DATA,
  input  logic              iBR_VALID,
  input  logic [ADDR_W-1:0] iBR_TARGET,
  output logic              oIR_VALID,
  input  logic              iIR_READY,
  output logic [31:0]       oIR,
  output logic [6:0]        oOPCODE,
  output logic [ADDR_W-1:0] oPC
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]       oFETCH_CNT,
  output logic [7:0]        oFLUSH_CNT
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_KILL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;

  logic [31:0]       fifo_ir [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_after;

  logic              pop;
  logic              push;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] seq_pc;

  assign pop         = (count_q != '0) && iIR_READY;
  // Redirect discards same-cycle ack data, so no push is allowed then.
  assign push        = iROM_ACK && (state_q == S_REQ) && !iBR_VALID;
  assign count_after = count_q - CNT_W'(pop) + CNT_W'(push);
  assign br_target   = iBR_TARGET & ~ADDR_W'(3);
  assign seq_pc      = req_addr_q + ADDR_W'(4);

  // Next-state logic for the fetch request FSM
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    if (iBR_VALID) begin
      fetch_pc_d = br_target;
      // A still-pending request must complete before the target may issue.
      if ((state_q != S_IDLE) && !iROM_ACK) begin
        state_d = S_KILL;
      end else begin
        state_d    = S_REQ;
        req_addr_d = br_target;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_after < DEPTH_C) begin
            state_d    = S_REQ;
            req_addr_d = fetch_pc_q;
          end
        end
        S_REQ: begin
          if (iROM_ACK) begin
            fetch_pc_d = seq_pc;
            if (count_after < DEPTH_C) begin
              req_addr_d = seq_pc;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_KILL: begin
          if (iROM_ACK) begin
            state_d    = S_REQ;
            req_addr_d = fetch_pc_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM and fetch address registers
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  // FIFO pointers and occupancy; redirect empties the FIFO
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (iBR_VALID) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_after;
    end
  end

  // FIFO storage; contents are only observed while occupied
  always_ff @(posedge iCLK) begin
    if (push) begin
      fifo_ir[wr_ptr_q] <= iROM_DATA;
      fifo_pc[wr_ptr_q] <= req_addr_q;
    end
  end

  assign oROM_REQ  = (state_q != S_IDLE);
  assign oROM_ADDR = req_addr_q;
  assign oIR_VALID = (count_q != '0);
  assign oIR       = oIR_VALID ? fifo_ir[rd_ptr_q] : '0;
  assign oPC       = oIR_VALID ? fifo_pc[rd_ptr_q] : '0;
  assign oOPCODE   = oIR[6:0];

`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt_q;
  logic [7:0]  flush_cnt_q;

  // Saturating accepted-instruction and redirect counters
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (oIR_VALID && iIR_READY && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (iBR_VALID && (flush_cnt_q != '1))              flush_cnt_q <= flush_cnt_q + 8'd1;
    end
  end

  assign oFETCH_CNT = fetch_cnt_q;
  assign oFLUSH_CNT = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a ROM responder process, a stimulus
// process and a negedge monitor that checks the accepted instruction stream
// against an expected-PC queue built from sequential +4 / redirect rules.
module tb_fetch_unit;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned AW    = 8;

  logic          iCLK = 1'b0;
  logic          iRST;
  logic          oROM_REQ;
  logic [AW-1:0] oROM_ADDR;
  logic          iROM_ACK;
  logic [31:0]   iROM_DATA;
  logic          iBR_VALID;
  logic [AW-1:0] iBR_TARGET;
  logic          oIR_VALID;
  logic          iIR_READY;
  logic [31:0]   oIR;
  logic [6:0]    oOPCODE;
  logic [AW-1:0] oPC;
`ifdef FETCH_STATS_EN
  logic [15:0]   oFETCH_CNT;
  logic [7:0]    oFLUSH_CNT;
`endif

  always #5 iCLK = ~iCLK;

  fetch_unit #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .RESET_PC(8'h00)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .oROM_REQ(oROM_REQ), .oROM_ADDR(oROM_ADDR),
    .iROM_ACK(iROM_ACK), .iROM_DATA(iROM_DATA),
    .iBR_VALID(iBR_VALID), .iBR_TARGET(iBR_TARGET),
    .oIR_VALID(oIR_VALID), .iIR_READY(iIR_READY),
    .oIR(oIR), .oOPCODE(oOPCODE), .oPC(oPC)
`ifdef FETCH_STATS_EN
    , .oFETCH_CNT(oFETCH_CNT), .oFLUSH_CNT(oFLUSH_CNT)
`endif
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    return {~a, a ^ 8'h5A, a, 8'h13};
  endfunction

  // ROM responder controls
  int unsigned dly_lo = 0, dly_hi = 0;
  int unsigned rom_wait = 0, rom_delay = 0;
  int unsigned ack_total = 0;
  bit          spurious_en = 1'b0;
  bit          force_ack = 1'b0;

  // ROM responder: acks the outstanding request after a chosen delay
  initial begin
    iROM_ACK  = 1'b0;
    iROM_DATA = '0;
    forever begin
      @(posedge iCLK);
      if (iROM_ACK) ack_total++;
      #1;
      if (force_ack) begin
        iROM_ACK  = 1'b1;
        iROM_DATA = 32'hDEAD_BEEF;
        rom_wait  = 0;
      end else if (iRST && oROM_REQ) begin
        if (rom_wait >= rom_delay) begin
          iROM_ACK  = 1'b1;
          iROM_DATA = rom_word(oROM_ADDR);
          rom_wait  = 0;
          rom_delay = $urandom_range(dly_hi, dly_lo);
        end else begin
          iROM_ACK  = 1'b0;
          iROM_DATA = $urandom;
          rom_wait++;
        end
      end else begin
        rom_wait  = 0;
        iROM_ACK  = spurious_en && ($urandom_range(3, 0) == 0);
        iROM_DATA = $urandom;
      end
    end
  end

  // Expected stream model and previous-cycle observations
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_next;
  logic [AW-1:0] exp_pc;
  logic [31:0]   exp_w;
  bit            pv_ok = 1'b0;
  logic          pv_valid, pv_ready, pv_br, pv_req, pv_ack;
  logic [AW-1:0] pv_pc, pv_addr;
  logic [31:0]   pv_ir;
  int unsigned   accepts = 0;
  int unsigned   model_fetch = 0, model_flush = 0;

  // Monitor: protocol checks and in-order stream scoreboard
  always @(negedge iCLK) begin
    if (!iRST) begin
      exp_q.delete();
      exp_next    = 8'h00;
      pv_ok       = 1'b0;
      model_fetch = 0;
      model_flush = 0;
    end else begin
`ifdef FETCH_STATS_EN
      chk("fetch_cnt", 32'(oFETCH_CNT), 32'(model_fetch));
      chk("flush_cnt", 32'(oFLUSH_CNT), 32'(model_flush));
`endif
      if (pv_ok) begin
        if (pv_req && !pv_ack) begin
          chk("rom_req_hold", 32'(oROM_REQ), 32'd1);
          chk("rom_addr_hold", 32'(oROM_ADDR), 32'(pv_addr));
        end
        if (pv_br) begin
          chk("flush_valid", 32'(oIR_VALID), 32'd0);
        end else if (pv_valid && !pv_ready) begin
          chk("stall_valid", 32'(oIR_VALID), 32'd1);
          chk("stall_pc", 32'(oPC), 32'(pv_pc));
          chk("stall_ir", oIR, pv_ir);
        end
      end
      if (oIR_VALID && iIR_READY) begin
        accepts++;
        if (model_fetch < 65535) model_fetch++;
        exp_pc = exp_q.pop_front();
        exp_w  = rom_word(exp_pc);
        chk("stream_pc", 32'(oPC), 32'(exp_pc));
        chk("stream_ir", oIR, exp_w);
        chk("stream_opcode", 32'(oOPCODE), 32'(exp_w[6:0]));
      end
      if (iBR_VALID) begin
        if (model_flush < 255) model_flush++;
        exp_q.delete();
        exp_next = iBR_TARGET & 8'hFC;
      end
      while (exp_q.size() < 8) begin
        exp_q.push_back(exp_next);
        exp_next = exp_next + 8'd4;
      end
      pv_valid = oIR_VALID;  pv_ready = iIR_READY;  pv_br = iBR_VALID;
      pv_req   = oROM_REQ;   pv_ack   = iROM_ACK;   pv_addr = oROM_ADDR;
      pv_pc    = oPC;        pv_ir    = oIR;        pv_ok = 1'b1;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(oROM_REQ),  32'd0);
    chk({tag, "_addr"},  32'(oROM_ADDR), 32'h00);
    chk({tag, "_valid"}, 32'(oIR_VALID), 32'd0);
    chk({tag, "_ir"},    oIR,            32'd0);
    chk({tag, "_op"},    32'(oOPCODE),   32'd0);
    chk({tag, "_pc"},    32'(oPC),       32'd0);
  endtask

  task automatic redirect(input logic [AW-1:0] tgt);
    @(posedge iCLK); #1;
    iBR_VALID  = 1'b1;
    iBR_TARGET = tgt;
    @(posedge iCLK); #1;
    iBR_VALID  = 1'b0;
  endtask

  // Stimulus: directed scenarios then randomized traffic
  initial begin
    int unsigned t;
    int unsigned base;
    bit ok;
    logic [AW-1:0] held;

    iRST = 1'b0; iIR_READY = 1'b0; iBR_VALID = 1'b0; iBR_TARGET = '0;
    repeat (3) @(negedge iCLK);
    check_reset_outputs("reset");

    // Streaming with immediate acks and READY=1
    iIR_READY = 1'b1;
    @(posedge iCLK); #1 iRST = 1'b1;
    t = 0; ok = 1'b0;
    while (!ok && t < 4) begin @(negedge iCLK); ok = oROM_REQ; t++; end
    chk("first_req_seen", 32'(ok), 32'd1);
    chk("first_req_addr", 32'(oROM_ADDR), 32'h00);
    t = 0; ok = 1'b0;
    while (!ok && t < 4) begin @(negedge iCLK); ok = oIR_VALID; t++; end
    chk("first_valid_seen", 32'(ok), 32'd1);
    for (int i = 0; i < 16; i++) begin
      @(negedge iCLK);
      chk("no_gap_valid", 32'(oIR_VALID), 32'd1);
    end

    // Stall: exactly DEPTH words fetched, then request stops
    @(posedge iCLK); #1;
    iBR_VALID = 1'b1; iBR_TARGET = 8'h80; iIR_READY = 1'b0;
    @(posedge iCLK); #1 iBR_VALID = 1'b0;
    @(negedge iCLK);
    base = ack_total;
    repeat (10) @(negedge iCLK);
    chk("stall_ack_count", ack_total - base, DEPTH);
    chk("stall_req_off", 32'(oROM_REQ), 32'd0);
    chk("stall_head_pc", 32'(oPC), 32'h80);
    @(posedge iCLK); #1 iIR_READY = 1'b1;
    repeat (12) @(negedge iCLK);

    // Redirect while a delayed ack is pending
    dly_lo = 3; dly_hi = 3;
    t = 0; ok = 1'b0;
    while (!ok && t < 40) begin
      @(negedge iCLK);
      ok = oROM_REQ && !iROM_ACK && (rom_wait == 1) && (rom_delay == 3);
      t++;
    end
    chk("kill_setup_seen", 32'(ok), 32'd1);
    held = oROM_ADDR;
    redirect(8'h42);
    dly_lo = 0; dly_hi = 0;
    t = 0; ok = 1'b0;
    while (!ok && t < 8) begin @(negedge iCLK); ok = iROM_ACK; t++; end
    chk("kill_ack_seen", 32'(ok), 32'd1);
    chk("kill_addr_held", 32'(oROM_ADDR), 32'(held));
    @(negedge iCLK);
    chk("kill_next_req", 32'(oROM_REQ), 32'd1);
    chk("kill_next_addr", 32'(oROM_ADDR), 32'h40);
    t = 0; ok = 1'b0;
    while (!ok && t < 10) begin @(negedge iCLK); ok = oIR_VALID; t++; end
    chk("kill_next_pc", 32'(oPC), 32'h40);

    // Redirect coinciding with a pop and an ack
    t = 0; ok = 1'b0;
    while (!ok && t < 40) begin
      @(negedge iCLK); ok = oIR_VALID && oROM_REQ && (rom_delay == 0); t++;
    end
    chk("brpop_setup_seen", 32'(ok), 32'd1);
    @(posedge iCLK); #1;
    iBR_VALID = 1'b1; iBR_TARGET = 8'h20;
    @(negedge iCLK);
    chk("brpop_pop", 32'(oIR_VALID && iIR_READY), 32'd1);
    chk("brpop_ack", 32'(iROM_ACK), 32'd1);
    @(posedge iCLK); #1 iBR_VALID = 1'b0;
    @(negedge iCLK);
    chk("brpop_empty", 32'(oIR_VALID), 32'd0);
    t = 0; ok = 1'b0;
    while (!ok && t < 6) begin @(negedge iCLK); ok = oIR_VALID; t++; end
    chk("brpop_next_pc", 32'(oPC), 32'h20);

    // Address wrap from the top of the space
    base = accepts;
    redirect(8'hFA);
    t = 0;
    while ((accepts - base) < 4 && t < 20) begin @(negedge iCLK); t++; end
    chk("wrap_progress", 32'((accepts - base) >= 4), 32'd1);

    // Reset during an outstanding request, late ack after release
    dly_lo = 5; dly_hi = 5;
    t = 0; ok = 1'b0;
    while (!ok && t < 60) begin
      @(negedge iCLK); ok = oROM_REQ && !iROM_ACK && (rom_delay == 5); t++;
    end
    chk("rst_setup_seen", 32'(ok), 32'd1);
    #2 iRST = 1'b0;
    #1 check_reset_outputs("midreset");
    force_ack = 1'b1;
    @(posedge iCLK);
    @(negedge iCLK);
    check_reset_outputs("ackreset");
    @(posedge iCLK); #3 iRST = 1'b1;
    @(posedge iCLK);
    force_ack = 1'b0;
    dly_lo = 0; dly_hi = 0;
    @(negedge iCLK);
    chk("restart_req", 32'(oROM_REQ), 32'd1);
    chk("restart_addr", 32'(oROM_ADDR), 32'h00);
    chk("late_ack_ignored", 32'(oIR_VALID), 32'd0);
    t = 0; ok = 1'b0;
    while (!ok && t < 12) begin @(negedge iCLK); ok = oIR_VALID; t++; end
    chk("restart_pc", 32'(oPC), 32'h00);
    chk("restart_ir", oIR, rom_word(8'h00));

    // Randomized traffic
    dly_lo = 0; dly_hi = 3; spurious_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge iCLK); #1;
      iIR_READY  = ($urandom_range(3, 0) != 0);
      iBR_VALID  = ($urandom_range(24, 0) == 0);
      iBR_TARGET = 8'($urandom);
    end
    @(posedge iCLK); #1;
    iBR_VALID = 1'b0; iIR_READY = 1'b1;
    spurious_en = 1'b0;
    repeat (8) @(negedge iCLK);

`ifdef FETCH_STATS_EN
    dly_hi = 0;
    repeat (70000) @(negedge iCLK);
    chk("fetch_cnt_sat", 32'(oFETCH_CNT), 32'h0000_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound
  initial begin
    #1500000;
    miscompares++;
    $display("FAIL watchdog: got timeout expected completion at t=%0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
